commit_trace_fifo: RTL
======================

// Module: commit_trace_fifo
// PURPOSE
//  Sits directly downstream of the cpu core's retire/writeback point, upstream of trace/log consumers.
//  Classifies each committed instruction (reg write, load, store, halt, branch/nop), tags it with a
//  sequential instruction number, and buffers the record in a FIFO drained via valid/ready.
//  Also keeps a cycle counter with watchdog timeout and reports halted/drained status.
// PARAMETERS
//  DEPTH       16      FIFO entries; power of 2, >= 2
//  INUM_W      32      instruction-number width
//  CYC_W       32      cycle-counter width
//  MAX_CYCLES  100000  watchdog limit; timeout once cycle_count > MAX_CYCLES
// PORTS
//  clk           in   1       clock, all state on rising edge
//  rst_n         in   1       reset, synchronous, active-low
//  commit_valid  in   1       one instruction retires this cycle
//  commit_pc     in   16      PC of retiring instruction
//  reg_write     in   1       register file written
//  wr_reg        in   4       destination register
//  wr_data       in   16      register write data
//  mem_read      in   1       memory read performed
//  mem_write     in   1       memory write performed
//  mem_addr      in   16      memory address
//  mem_data      in   16      memory store data
//  halt          in   1       halt instruction retiring
//  out_valid     out  1       head record available
//  out_ready     in   1       consumer accepts head record
//  out_type      out  3       0 NOP/BR, 1 REG, 2 LOAD, 3 STORE, 4 HALT
//  out_inum      out  INUM_W  instruction number
//  out_pc        out  16      PC
//  out_reg       out  4       dst reg (REG/LOAD), else 0
//  out_value     out  16      wr_data (REG/LOAD), mem_data (STORE), else 0
//  out_addr      out  16      mem_addr (LOAD/STORE), else 0
//  count         out  $clog2(DEPTH)+1  FIFO occupancy
//  overflow      out  1       sticky: a record was dropped on full
//  halted        out  1       sticky: HALT record captured
//  done          out  1       halted & FIFO empty
//  timeout       out  1       sticky watchdog flag
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): FIFO flushed, all outputs 0, inum=0, cycle_count=0; applies mid-operation, pending records lost.
//  - Capture: event = commit_valid & ~halted. Classify by priority: reg_write&mem_read->LOAD;
//    reg_write->REG; halt->HALT; mem_write->STORE; else NOP/BR. Unused fields forced to 0.
//  - inum: each event gets current inum, then inum+1 (wraps at 2^INUM_W). Dropped events still consume a number.
//  - Push when event & (count<DEPTH | (out_valid&out_ready)); full with simultaneous pop accepts push, count unchanged.
//  - Event while full and no pop: record dropped, overflow set (sticky until reset).
//  - Latency: record captured at edge N is visible on out_* with out_valid=1 after edge N (registered; no bypass, also when empty).
//  - Pop: out_valid&out_ready at edge removes head; out_* hold stable while out_valid&~out_ready.
//  - out_* registered/read from storage; out_valid = (count!=0). Pointers wrap modulo DEPTH.
//  - HALT event sets halted; all later commit_valid ignored (no inum increment). HALT record itself still subject to full/drop rule (overflow flags loss).
//  - done = halted & (count==0), combinational from registers.
//  - cycle_count increments every clock out of reset, saturates at all-ones; timeout set when cycle_count > MAX_CYCLES, sticky; does not block capture.
// TESTING
//  - Reset then commit REG pc=0x0002 r3=0x1234 -> next cycle out_valid=1, type=1, inum=0, reg=3, value=0x1234, addr=0.
//  - Load (reg_write&mem_read, r5, data 0xBEEF, addr 0x0040) then store (addr 0x0042, data 0x00AA) -> types 2,3 inum 0,1 with those addr/value.
//  - out_ready=0, 17 events into DEPTH=16 -> count=16, overflow=1, 17th dropped; draining gives inum 0..15, next accepted event inum=17.
//  - Full FIFO, event with out_ready=1 same cycle -> count stays 16, overflow stays 0, new record at tail.
//  - HALT at pc 0x0010 then 3 more commits -> only HALT stored (type 4); after drain done=1; inum stops.
//  - MAX_CYCLES=20, no halt -> timeout rises after edge where cycle_count reaches 21; rst_n low mid-stream -> count=0, flags 0, inum restarts 0.

Source files
------------

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: classifies each retiring instruction, numbers it and buffers the trace record
// in a valid/ready FIFO; also runs a saturating cycle counter with a sticky watchdog flag.
module commit_trace_fifo #(
    parameter int DEPTH      = 16,
    parameter int INUM_W     = 32,
    parameter int CYC_W      = 32,
    parameter int MAX_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       commit_valid,
    input  logic [15:0]                commit_pc,
    input  logic                       reg_write,
    input  logic [3:0]                 wr_reg,
    input  logic [15:0]                wr_data,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [15:0]                mem_addr,
    input  logic [15:0]                mem_data,
    input  logic                       halt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_type,
    output logic [INUM_W-1:0]          out_inum,
    output logic [15:0]                out_pc,
    output logic [3:0]                 out_reg,
    output logic [15:0]                out_value,
    output logic [15:0]                out_addr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       halted,
    output logic                       done,
    output logic                       timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] T_NOP = 3'd0, T_REG = 3'd1, T_LOAD = 3'd2, T_STORE = 3'd3, T_HALT = 3'd4;

    logic [2:0]        type_mem  [DEPTH];
    logic [INUM_W-1:0] inum_mem  [DEPTH];
    logic [15:0]       pc_mem    [DEPTH];
    logic [3:0]        reg_mem   [DEPTH];
    logic [15:0]       value_mem [DEPTH];
    logic [15:0]       addr_mem  [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [INUM_W-1:0] inum_q, inum_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic              overflow_q, overflow_d, halted_q, halted_d, timeout_q, timeout_d;
    logic              evt, pop, push, has_reg;
    logic [2:0]        c_type;
    logic [3:0]        c_reg;
    logic [15:0]       c_value, c_addr;

    always_comb begin
        evt        = commit_valid & ~halted_q;
        pop        = out_valid & out_ready;
        // count MSB set means exactly DEPTH entries since DEPTH is a power of two
        push       = evt & (~count_q[CW-1] | pop);
        c_type     = (reg_write & mem_read) ? T_LOAD :
                     reg_write              ? T_REG  :
                     halt                   ? T_HALT :
                     mem_write              ? T_STORE : T_NOP;
        has_reg    = (c_type == T_REG) | (c_type == T_LOAD);
        c_reg      = has_reg ? wr_reg : 4'd0;
        c_value    = has_reg ? wr_data : (c_type == T_STORE) ? mem_data : 16'd0;
        c_addr     = (c_type == T_LOAD || c_type == T_STORE) ? mem_addr : 16'd0;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        inum_d     = evt ? inum_q + INUM_W'(1) : inum_q;
        overflow_d = overflow_q | (evt & ~push);
        halted_d   = halted_q | (evt & (c_type == T_HALT));
        cyc_d      = (&cyc_q) ? cyc_q : cyc_q + CYC_W'(1);
        timeout_d  = timeout_q | (cyc_d > CYC_W'(MAX_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inum_q     <= '0;
            cyc_q      <= '0;
            overflow_q <= 1'b0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inum_q     <= inum_d;
            cyc_q      <= cyc_d;
            overflow_q <= overflow_d;
            halted_q   <= halted_d;
            timeout_q  <= timeout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            type_mem[wr_ptr_q]  <= c_type;
            inum_mem[wr_ptr_q]  <= inum_q;
            pc_mem[wr_ptr_q]    <= commit_pc;
            reg_mem[wr_ptr_q]   <= c_reg;
            value_mem[wr_ptr_q] <= c_value;
            addr_mem[wr_ptr_q]  <= c_addr;
        end
    end

    // Storage is not reset, so record fields are masked whenever the FIFO is empty
    assign out_valid = |count_q;
    assign out_type  = out_valid ? type_mem[rd_ptr_q]  : 3'd0;
    assign out_inum  = out_valid ? inum_mem[rd_ptr_q]  : '0;
    assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : 16'd0;
    assign out_reg   = out_valid ? reg_mem[rd_ptr_q]   : 4'd0;
    assign out_value = out_valid ? value_mem[rd_ptr_q] : 16'd0;
    assign out_addr  = out_valid ? addr_mem[rd_ptr_q]  : 16'd0;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign halted    = halted_q;
    assign done      = halted_q & ~out_valid;
    assign timeout   = timeout_q;
endmodule
